// File: rtl/syntrim_ctrl.sv
// Frame-phase trim controller: steers line length hlen so the internal frame rate tracks the external sync.
// Optional build macro SYNTRIM_FAST_ACQ_EN: use a correction step of 4 while acquiring.
module syntrim_ctrl #(
  parameter int HNOM     = 1064,
  parameter int TRIM_MAX = 15,
  parameter int LOCK_CNT = 16,
  parameter int ERR_LIM  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fr,
  input  logic              extsyn,
  input  logic              uph,
  input  logic              downh,
  input  logic              beginsyn,
  input  logic              tv,
  output logic [10:0]       hlen,
  output logic signed [5:0] trim,
  output logic              restart,
  output logic              locked,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {FREE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOCK = 2'd3} state_t;

  localparam logic signed [6:0] TMAX   = 7'(TRIM_MAX);
  localparam logic signed [6:0] TMAX_N = -TMAX;

  state_t            st;
  logic [1:0]        fr_q;
  logic              fu, fd;
  logic [7:0]        lock_cnt;
  logic [3:0]        err_cnt;

  logic              fu_e, fd_e, inc, dec, over;
  logic signed [6:0] step, trim_x, req;
  logic signed [5:0] trim_nxt;
  logic [3:0]        err_nxt;
  logic [7:0]        lock_nxt;

  assign state = st;

  function automatic logic [10:0] nominal(input logic [1:0] f);
    return 11'(HNOM >> f);
  endfunction

  function automatic logic signed [5:0] sat_trim(input logic signed [6:0] r);
    if (r > TMAX)        return TMAX[5:0];
    else if (r < TMAX_N) return TMAX_N[5:0];
    else                 return r[5:0];
  endfunction

  // Nominal plus sign-extended trim in 12 bits, truncated to the 11-bit port.
  function automatic logic [10:0] calc_hlen(input logic [1:0] f, input logic signed [5:0] t);
    logic [11:0] s;
    s = {1'b0, nominal(f)} + {{6{t[5]}}, t};
    return s[10:0];
  endfunction

  // Frame-end evaluation; pulses arriving together with tv belong to the ending frame.
  always_comb begin
    fu_e = fu | uph;
    fd_e = fd | downh;
    inc  = fd_e & ~fu_e;
    dec  = fu_e & ~fd_e;
`ifdef SYNTRIM_FAST_ACQ_EN
    step = (st == ACQ) ? 7'sd4 : 7'sd1;
`else
    step = 7'sd1;
`endif
    trim_x   = {trim[5], trim};
    req      = trim_x + (inc ? step : (dec ? -step : 7'sd0));
    trim_nxt = sat_trim(req);
    // Only a request made while already pinned at the clamp is an error.
    over     = (inc && trim_x >= TMAX) || (dec && trim_x <= TMAX_N);
    err_nxt  = err_cnt + 4'd1;
    lock_nxt = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= FREE;
      trim     <= '0;
      hlen     <= nominal(fr);
      restart  <= 1'b0;
      locked   <= 1'b0;
      fr_q     <= fr;
      fu       <= 1'b0;
      fd       <= 1'b0;
      lock_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      restart <= 1'b0;
      if (fr != fr_q) begin
        fr_q <= fr;
        hlen <= nominal(fr);
        fu   <= 1'b0;
        fd   <= 1'b0;
        if (st != FREE) begin
          st       <= ACQ;
          trim     <= '0;
          restart  <= 1'b1;
          locked   <= 1'b0;
          lock_cnt <= '0;
          err_cnt  <= '0;
        end
      end else if (!extsyn) begin
        st       <= FREE;
        trim     <= '0;
        locked   <= 1'b0;
        fu       <= 1'b0;
        fd       <= 1'b0;
        lock_cnt <= '0;
        err_cnt  <= '0;
        if (tv) hlen <= nominal(fr_q);
      end else if (st == FREE || beginsyn) begin
        st       <= ACQ;
        trim     <= '0;
        restart  <= 1'b1;
        locked   <= 1'b0;
        fu       <= 1'b0;
        fd       <= 1'b0;
        lock_cnt <= '0;
        err_cnt  <= '0;
      end else if (tv) begin
        fu <= 1'b0;
        fd <= 1'b0;
        if (over && err_nxt == 4'(ERR_LIM)) begin
          st       <= ACQ;
          trim     <= '0;
          hlen     <= nominal(fr_q);
          restart  <= 1'b1;
          locked   <= 1'b0;
          lock_cnt <= '0;
          err_cnt  <= '0;
        end else begin
          trim    <= trim_nxt;
          hlen    <= calc_hlen(fr_q, trim_nxt);
          err_cnt <= over ? err_nxt : 4'd0;
          if (fu_e || fd_e) begin
            lock_cnt <= '0;
            if (st == LOCK) begin
              st     <= TRACK;
              locked <= 1'b0;
            end else if (st == ACQ && (inc || dec)) begin
              st <= TRACK;
            end
          end else begin
            lock_cnt <= lock_nxt;
            if (lock_nxt >= 8'(LOCK_CNT) && st != LOCK) begin
              st     <= LOCK;
              locked <= 1'b1;
            end
          end
        end
      end else begin
        fu <= fu | uph;
        fd <= fd | downh;
      end
    end
  end

endmodule

// File: tb/tb_syntrim_ctrl.sv
// Directed bench for syntrim_ctrl: expected outputs are queued per step and checked one cycle later.
module tb_syntrim_ctrl;

`ifdef SYNTRIM_FAST_ACQ_EN
  localparam int S = 4;
`else
  localparam int S = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        fr = 2'd2;
  logic              extsyn = 1'b0, uph = 1'b0, downh = 1'b0, beginsyn = 1'b0, tv = 1'b0;
  logic [10:0]       hlen;
  logic signed [5:0] trim;
  logic              restart, locked;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    h;
    int    tr;
    bit    rs;
    bit    lk;
    int    st;
  } exp_t;

  exp_t q[$];

  syntrim_ctrl dut (
    .clk(clk), .rst(rst), .fr(fr), .extsyn(extsyn), .uph(uph), .downh(downh),
    .beginsyn(beginsyn), .tv(tv), .hlen(hlen), .trim(trim), .restart(restart),
    .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic push(input string tag, input int h, input int tr, input bit rs, input bit lk, input int st);
    exp_t e;
    e.tag = tag; e.h = h; e.tr = tr; e.rs = rs; e.lk = lk; e.st = st;
    q.push_back(e);
  endtask

  task automatic tick(input logic u, input logic d, input logic b, input logic t);
    uph = u; downh = d; beginsyn = b; tv = t;
    @(posedge clk);
    #1;
    uph = 1'b0; downh = 1'b0; beginsyn = 1'b0; tv = 1'b0;
  endtask

  task automatic check();
    exp_t e;
    logic [20:0] o, x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued, got hlen=%0d", hlen);
      return;
    end
    e = q.pop_front();
    o = {hlen, trim, restart, locked, state};
    x = {11'(e.h), 6'(e.tr), e.rs, e.lk, 2'(e.st)};
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: got hlen=%0d trim=%0d restart=%0b locked=%0b state=%0d; want hlen=%0d trim=%0d restart=%0b locked=%0b state=%0d",
             e.tag, hlen, trim, restart, locked, state, e.h, e.tr, e.rs, e.lk, e.st);
    end
  endtask

  task automatic step_chk(input string tag, input logic u, input logic d, input logic b, input logic t,
                          input int h, input int tr, input bit rs, input bit lk, input int st);
    push(tag, h, tr, rs, lk, st);
    tick(u, d, b, t);
    check();
  endtask

  // One frame: optional flag pulse, idle cycle, then tv with the result checked at T+1.
  task automatic frame(input string tag, input logic u, input logic d,
                       input int h, input int tr, input bit rs, input bit lk, input int st);
    tick(u, d, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    step_chk(tag, 1'b0, 1'b0, 1'b0, 1'b1, h, tr, rs, lk, st);
  endtask

  initial begin
    step_chk("reset", 0, 0, 0, 0, 266, 0, 0, 0, 0);
    rst = 1'b0;

    frame("free_tv1", 0, 0, 266, 0, 0, 0, 0);
    frame("free_tv2", 1, 0, 266, 0, 0, 0, 0);
    frame("free_tv3", 0, 1, 266, 0, 0, 0, 0);

    fr = 2'd0;
    step_chk("free_fr_change", 0, 0, 0, 0, 1064, 0, 0, 0, 0);
    extsyn = 1'b1;
    step_chk("acq_restart", 0, 0, 0, 0, 1064, 0, 1, 0, 1);
    step_chk("restart_one_clk", 0, 0, 0, 0, 1064, 0, 0, 0, 1);

    frame("uph1", 1, 0, 1064 - S, -S, 0, 0, 2);
    frame("uph2", 1, 0, 1063 - S, -S - 1, 0, 0, 2);
    frame("uph3", 1, 0, 1062 - S, -S - 2, 0, 0, 2);

    for (int i = 1; i <= 15; i++) frame("clean_prelock", 0, 0, 1062 - S, -S - 2, 0, 0, 2);
    frame("lock16", 0, 0, 1062 - S, -S - 2, 0, 1, 3);
    frame("unlock_downh", 0, 1, 1063 - S, -S - 1, 0, 0, 2);

    for (int i = -S; i <= 15; i++) frame("ramp_up", 0, 1, 1064 + i, i, 0, 0, 2);
    for (int i = 1; i <= 3; i++) frame("clamp_hold", 0, 1, 1079, 15, 0, 0, 2);
    frame("err_resync", 0, 1, 1064, 0, 1, 0, 1);
    step_chk("err_restart_end", 0, 0, 0, 0, 1064, 0, 0, 0, 1);

    frame("track_again", 1, 0, 1064 - S, -S, 0, 0, 2);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    step_chk("beginsyn_tv", 1, 0, 1, 1, 1064 - S, 0, 1, 0, 1);
    frame("clean_after_bs", 0, 0, 1064, 0, 0, 0, 1);

    frame("track_pre_fr", 1, 0, 1064 - S, -S, 0, 0, 2);
    fr = 2'd3;
    step_chk("fr_change_track", 0, 0, 0, 0, 133, 0, 1, 0, 1);

    frame("acq_fr3", 0, 1, 133 + S, S, 0, 0, 2);
    extsyn = 1'b0;
    step_chk("extsyn_off", 0, 0, 0, 0, 133 + S, 0, 0, 0, 0);
    frame("free_reload", 0, 0, 133, 0, 0, 0, 0);

    extsyn = 1'b1;
    step_chk("reacq", 0, 0, 0, 0, 133, 0, 1, 0, 1);
    frame("pre_reset", 1, 0, 133 - S, -S, 0, 0, 2);
    tick(1, 0, 0, 0);
    rst = 1'b1;
    step_chk("mid_frame_reset", 1, 0, 0, 0, 133, 0, 0, 0, 0);
    rst = 1'b0;

    step_chk("post_reset_acq", 0, 0, 0, 0, 133, 0, 1, 0, 1);
    frame("acq_step1", 0, 1, 133 + S, S, 0, 0, 2);
    frame("acq_step2", 0, 1, 134 + S, S + 1, 0, 0, 2);
    frame("acq_step3", 0, 1, 135 + S, S + 2, 0, 0, 2);
    frame("acq_step4", 0, 1, 136 + S, S + 3, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syntrim_ctrl.md
# syntrim_ctrl

Frame-phase trim controller for the camera timing generator in external-sync mode. Consumes the phase-error indications (`uph`, `downh`, `beginsyn`) produced by the external-sync comparator and adjusts the line length `hlen` fed to the sensor timing generator. Corrections are applied only at frame boundaries, so the internal frame rate converges on the external 60 Hz reference. Also sequences hard restarts and reports lock status.

## Interface
- `HNOM`, 1064: line length in clocks at `fr`=0; nominal for `fr`=n is `HNOM>>n` (1064/532/266/133).
- `TRIM_MAX`, 15: trim clamp magnitude, 1..31.
- `LOCK_CNT`, 16: consecutive clean frames required to declare lock, 1..255.
- `ERR_LIM`, 4: consecutive frames requesting correction beyond the clamp before a forced resync, 1..15.

- `clk`  in  1  65.625 MHz system clock.
- `rst`  in  1  synchronous reset, active-high.
- `fr`  in  2  frame-rate select.
- `extsyn`  in  1  1 = external-sync mode enabled.
- `uph`  in  1  external sync leads; shorten lines.
- `downh`  in  1  external sync lags; lengthen lines.
- `beginsyn`  in  1  one-clk hard-resync request.
- `tv`  in  1  one-clk internal frame-start pulse.
- `hlen`  out  11  line length to the timing generator.
- `trim`  out  6  signed two's-complement current trim.
- `restart`  out  1  one-clk pulse; the timing generator restarts its frame.
- `locked`  out  1  phase lock achieved.
- `state`  out  2  0 FREE, 1 ACQ, 2 TRACK, 3 LOCK.

## Operation
- Reset: `state`=FREE, `trim`=0, `hlen`=`HNOM>>fr`, `restart`=0, `locked`=0, all counters and flags 0.
- Sticky flags `fu`/`fd` are set by `uph`/`downh` during a frame and cleared after each `tv` evaluation. Pulses coinciding with `tv` count toward the ending frame.
- Per-cycle event priority: `rst` > `fr` change > `extsyn`=0 > `beginsyn` > `tv` evaluation.
- **`fr` change** (`fr`≠registered `fr`):
  - in non-FREE states: `trim`=0, `hlen`=new nominal, `restart` pulse, go to ACQ;
  - in FREE: `hlen`=new nominal, no pulse.
- **`extsyn`=0**: go to FREE; `trim`=0; `locked`=0; `hlen` reloads to nominal at the next `tv`.
- **FREE → ACQ** on `extsyn`=1, with a `restart` pulse.
- **`beginsyn`** while `extsyn`=1: `restart` pulse, `trim`=0, counters cleared, go to ACQ.
- **`tv` evaluation** in ACQ/TRACK/LOCK:
  - `fu`&~`fd`: `trim` -= step.
  - `fd`&~`fu`: `trim` += step.
  - both or neither: no change.
  - step = 1.
- **Clamp**: the result saturates at ±`TRIM_MAX`.
  - A request that would exceed the clamp increments the error counter; any in-range or clean frame clears it.
  - When the error counter reaches `ERR_LIM`: `restart` pulse, `trim`=0, go to ACQ.
- **Lock counter**:
  - counts frames with neither flag set; cleared by any flag.
  - reaching `LOCK_CNT` moves ACQ/TRACK to LOCK, `locked`=1.
  - the first correction in ACQ moves to TRACK.
  - any flag in LOCK moves to TRACK, `locked`=0.
- **Width rules**:
  - `hlen` = `(HNOM>>fr)` + sign-extended `trim`, computed in 12 bits and truncated to 11.
  - Minimum nominal 133 > 31, so no underflow.

## Timing
- `tv` at cycle T: `trim`, `hlen`, `state`, and `locked` are updated at T+1.
- `restart` is high exactly one cycle, at T+1 after its trigger (`beginsyn`, `fr` change, FREE→ACQ, error limit).
- `hlen` never changes except at T+1 after `tv`, or on `fr` change/reset.
- `beginsyn` and `tv` in the same cycle: `beginsyn` wins, flags are discarded, and the next frame starts clean.
- `rst` mid-frame: all outputs reach reset values at the next edge; no `restart` pulse.

## Configuration
- `SYNTRIM_FAST_ACQ_EN` defined: the correction step is 4 while in ACQ, and 1 in TRACK/LOCK. The clamp still applies, and a partial step up to the clamp is accepted without counting an error.
- Undefined: the step is 1 in all states.

## Test plan
- Reset, `fr`=2, `extsyn`=0, 3 `tv` → `hlen`=266, `trim`=0, `state`=0, no `restart`.
- `extsyn` rises, `fr`=0 → `restart` one clk next cycle, `state`=1. Then `uph` in each of 3 frames → `trim`=-3, `hlen`=1061 at T+1 of third `tv`, `state`=2.
- Same as above, then 16 clean frames → `locked`=1 at T+1 of 16th `tv`. One `downh` → `locked`=0, `state`=2, `trim`=-2.
- 15 `downh` frames then 4 more → `trim`=15, `restart` at fourth excess `tv`+1, then `trim`=0, `state`=1.
- `beginsyn` coincident with `tv` while `uph` flagged → `restart`, `trim`=0, no step applied. `fr` changed 0→3 in TRACK → `hlen`=133, `restart`, `state`=1.
- With `SYNTRIM_FAST_ACQ_EN`, ACQ, 4 `downh` frames → `trim`=4 after first (state→TRACK), then 5, 6, 7.
